// File: rtl/params_pkg.sv
// Shared pipeline parameters and the hazard controller state encoding.
package params_pkg;

  localparam int REGISTER_WIDTH = 5;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } ctrl_state_t;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-to-hazard-controller signal bundle; master is the pipeline, slave the controller.
interface hazard_ctrl_if #(
  parameter int REGISTER_WIDTH = params_pkg::REGISTER_WIDTH,
  parameter int CNT_WIDTH      = 32
);

  logic                      dec_valid_i;
  logic [REGISTER_WIDTH-1:0] dec_rs_a_i;
  logic [REGISTER_WIDTH-1:0] dec_rs_b_i;
  logic                      dec_uses_a_i;
  logic                      dec_uses_b_i;
  logic                      alu_valid_i;
  logic                      alu_is_load_i;
  logic                      alu_reg_wr_en_i;
  logic [REGISTER_WIDTH-1:0] alu_wr_reg_i;
  logic                      alu_branch_taken_i;
  logic                      alu_is_jump_i;
  logic                      mem_stall_i;

  logic                      fetch_stall_o;
  logic                      decode_stall_o;
  logic                      alu_stall_o;
  logic                      fetch_kill_o;
  logic                      decode_kill_o;
  logic                      alu_kill_o;
  logic                      pc_redirect_o;
  logic [CNT_WIDTH-1:0]      stall_cnt_o;
  logic [CNT_WIDTH-1:0]      flush_cnt_o;

  modport master (
    output dec_valid_i, dec_rs_a_i, dec_rs_b_i, dec_uses_a_i, dec_uses_b_i,
           alu_valid_i, alu_is_load_i, alu_reg_wr_en_i, alu_wr_reg_i,
           alu_branch_taken_i, alu_is_jump_i, mem_stall_i,
    input  fetch_stall_o, decode_stall_o, alu_stall_o, fetch_kill_o,
           decode_kill_o, alu_kill_o, pc_redirect_o, stall_cnt_o, flush_cnt_o
  );

  modport slave (
    input  dec_valid_i, dec_rs_a_i, dec_rs_b_i, dec_uses_a_i, dec_uses_b_i,
           alu_valid_i, alu_is_load_i, alu_reg_wr_en_i, alu_wr_reg_i,
           alu_branch_taken_i, alu_is_jump_i, mem_stall_i,
    output fetch_stall_o, decode_stall_o, alu_stall_o, fetch_kill_o,
           decode_kill_o, alu_kill_o, pc_redirect_o, stall_cnt_o, flush_cnt_o
  );

endinterface

// File: rtl/hazard_ctrl_detect.sv
// Combinational load-use comparator between the ALU-stage load and the decode sources.
module hazard_detect
  import params_pkg::*;
#(
  parameter int REGISTER_WIDTH = params_pkg::REGISTER_WIDTH
) (
  input  logic                      alu_valid_i,
  input  logic                      alu_is_load_i,
  input  logic                      alu_reg_wr_en_i,
  input  logic [REGISTER_WIDTH-1:0] alu_wr_reg_i,
  input  logic                      dec_valid_i,
  input  logic                      dec_uses_a_i,
  input  logic                      dec_uses_b_i,
  input  logic [REGISTER_WIDTH-1:0] dec_rs_a_i,
  input  logic [REGISTER_WIDTH-1:0] dec_rs_b_i,
  output logic                      load_use_o
);

  logic load_in_alu;
  logic src_match;

  // r0 is compared like any other register
  assign load_in_alu = alu_valid_i & alu_is_load_i & alu_reg_wr_en_i & dec_valid_i;
  assign src_match   = (dec_uses_a_i & (dec_rs_a_i == alu_wr_reg_i)) |
                       (dec_uses_b_i & (dec_rs_b_i == alu_wr_reg_i));
  assign load_use_o  = load_in_alu & src_match;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use bubbles, branch/jump redirect with timed
// front-end flush, memory-stall freeze, and stall/flush performance counters.
//   state | meaning
//   RUN   | normal issue, load-use detection active
//   FLUSH | fetch output killed while fcnt counts down the in-flight fetches
module hazard_ctrl
  import params_pkg::*;
#(
  parameter int REGISTER_WIDTH = params_pkg::REGISTER_WIDTH,
  parameter int FLUSH_CYCLES   = 1,
  parameter int CNT_WIDTH      = 32
) (
  input  logic          clk_i,
  input  logic          rst_i,
  hazard_ctrl_if.slave  hz
);

  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES);

  ctrl_state_t          state_q, state_d;
  logic [3:0]           fcnt_q, fcnt_d;
  logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_WIDTH-1:0] flush_cnt_q, flush_cnt_d;

  logic load_use_raw;
  logic redirect;
  logic load_use;
  logic stall_evt;

  hazard_detect #(.REGISTER_WIDTH(REGISTER_WIDTH)) u_detect (
    .alu_valid_i     (hz.alu_valid_i),
    .alu_is_load_i   (hz.alu_is_load_i),
    .alu_reg_wr_en_i (hz.alu_reg_wr_en_i),
    .alu_wr_reg_i    (hz.alu_wr_reg_i),
    .dec_valid_i     (hz.dec_valid_i),
    .dec_uses_a_i    (hz.dec_uses_a_i),
    .dec_uses_b_i    (hz.dec_uses_b_i),
    .dec_rs_a_i      (hz.dec_rs_a_i),
    .dec_rs_b_i      (hz.dec_rs_b_i),
    .load_use_o      (load_use_raw)
  );

  // Priority: memory stall, then redirect, then load-use (RUN only)
  assign redirect  = ~hz.mem_stall_i & (hz.alu_branch_taken_i | hz.alu_is_jump_i);
  assign load_use  = ~hz.mem_stall_i & ~redirect & (state_q == RUN) & load_use_raw;
  assign stall_evt = hz.mem_stall_i | load_use;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= RUN;
      fcnt_q      <= 4'd0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      fcnt_q      <= fcnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    if (!hz.mem_stall_i) begin
      if (redirect) begin
        if (FLUSH_CYCLES > 0) begin
          state_d = FLUSH;
          fcnt_d  = FLUSH_LOAD;
        end
      end else if (state_q == FLUSH) begin
        fcnt_d = fcnt_q - 4'd1;
        if (fcnt_q <= 4'd1) begin
          state_d = RUN;
        end
      end
    end
    stall_cnt_d = stall_cnt_q + {{(CNT_WIDTH-1){1'b0}}, stall_evt};
    flush_cnt_d = flush_cnt_q + {{(CNT_WIDTH-1){1'b0}}, redirect};
  end

  always_comb begin
    hz.fetch_stall_o  = 1'b0;
    hz.decode_stall_o = 1'b0;
    hz.alu_stall_o    = 1'b0;
    hz.fetch_kill_o   = 1'b0;
    hz.decode_kill_o  = 1'b0;
    hz.alu_kill_o     = 1'b0;
    hz.pc_redirect_o  = 1'b0;
    if (!rst_i) begin
      if (hz.mem_stall_i) begin
        hz.fetch_stall_o  = 1'b1;
        hz.decode_stall_o = 1'b1;
        hz.alu_stall_o    = 1'b1;
      end else if (redirect) begin
        hz.pc_redirect_o  = 1'b1;
        hz.decode_kill_o  = 1'b1;
        hz.alu_kill_o     = 1'b1;
      end else if (state_q == FLUSH) begin
        hz.fetch_kill_o   = 1'b1;
      end else if (load_use) begin
        hz.fetch_stall_o  = 1'b1;
        hz.decode_stall_o = 1'b1;
        hz.alu_kill_o     = 1'b1;
      end
    end
  end

  assign hz.stall_cnt_o = stall_cnt_q;
  assign hz.flush_cnt_o = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl with FLUSH_CYCLES=2 and 4-bit counters.
module tb_hazard_ctrl;
  import params_pkg::*;

  localparam int RW = REGISTER_WIDTH;
  localparam int CW = 4;

  // ctl = {mem_stall, branch, jump, alu_valid, alu_load, alu_wr, dec_valid, uses_a, uses_b}
  // e   = {fetch_stall, decode_stall, alu_stall, fetch_kill, decode_kill, alu_kill, pc_redirect}
  typedef struct {
    logic [8:0]    ctl;
    logic [RW-1:0] ar;
    logic [RW-1:0] ra;
    logic [RW-1:0] rb;
    logic [6:0]    e;
  } vec_t;

  typedef struct {
    logic [6:0]    outs;
    logic [CW-1:0] sc;
    logic [CW-1:0] fc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  hazard_ctrl_if #(.REGISTER_WIDTH(RW), .CNT_WIDTH(CW)) hz();

  hazard_ctrl #(.REGISTER_WIDTH(RW), .FLUSH_CYCLES(2), .CNT_WIDTH(CW)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .hz    (hz)
  );

  int checks = 0;
  int errors = 0;
  logic [CW-1:0] sc_m = '0;
  logic [CW-1:0] fc_m = '0;
  exp_t sb[$];
  vec_t tbl[$];

  function automatic vec_t mk(input logic [8:0] c, input logic [RW-1:0] ar, ra, rb,
                              input logic [6:0] e);
    vec_t v;
    v.ctl = c; v.ar = ar; v.ra = ra; v.rb = rb; v.e = e;
    return v;
  endfunction

  function automatic logic [6:0] outs();
    return {hz.fetch_stall_o, hz.decode_stall_o, hz.alu_stall_o, hz.fetch_kill_o,
            hz.decode_kill_o, hz.alu_kill_o, hz.pc_redirect_o};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    {hz.mem_stall_i, hz.alu_branch_taken_i, hz.alu_is_jump_i, hz.alu_valid_i,
     hz.alu_is_load_i, hz.alu_reg_wr_en_i, hz.dec_valid_i, hz.dec_uses_a_i,
     hz.dec_uses_b_i} = v.ctl;
    hz.alu_wr_reg_i = v.ar;
    hz.dec_rs_a_i   = v.ra;
    hz.dec_rs_b_i   = v.rb;
  endtask

  task automatic step(input vec_t v, input string name);
    exp_t e;
    @(posedge clk);
    #1;
    drive(v);
    e.outs = v.e; e.sc = sc_m; e.fc = fc_m;
    sb.push_back(e);
    if (v.e[6]) sc_m = sc_m + 1'b1;
    if (v.e[0]) fc_m = fc_m + 1'b1;
    @(negedge clk);
    e = sb.pop_front();
    check({name, " outs"}, 32'(outs()), 32'(e.outs));
    check({name, " stall_cnt"}, 32'(hz.stall_cnt_o), 32'(e.sc));
    check({name, " flush_cnt"}, 32'(hz.flush_cnt_o), 32'(e.fc));
  endtask

  initial begin
    vec_t idle, lu, stl, br;
    idle = mk(9'b000000000, 5'd0, 5'd0, 5'd0, 7'b0000000);
    lu   = mk(9'b000111110, 5'd5, 5'd5, 5'd0, 7'b1100010);
    stl  = mk(9'b100000000, 5'd0, 5'd0, 5'd0, 7'b1110000);
    br   = mk(9'b010000000, 5'd0, 5'd0, 5'd0, 7'b0000111);

    tbl.push_back(idle);
    tbl.push_back(lu);                                                   // r5 load-use
    tbl.push_back(mk(9'b000000110, 5'd5, 5'd5, 5'd0, 7'b0000000));       // load gone: one bubble only
    tbl.push_back(mk(9'b000111101, 5'd5, 5'd5, 5'd3, 7'b0000000));       // uses_a=0
    tbl.push_back(mk(9'b000101110, 5'd5, 5'd5, 5'd0, 7'b0000000));       // not a load
    tbl.push_back(mk(9'b000111101, 5'd0, 5'd7, 5'd0, 7'b1100010));       // r0 via rs_b
    tbl.push_back(mk(9'b000110110, 5'd5, 5'd5, 5'd0, 7'b0000000));       // no reg write
    tbl.push_back(mk(9'b000111010, 5'd5, 5'd5, 5'd0, 7'b0000000));       // decode invalid
    tbl.push_back(br);
    tbl.push_back(mk(9'b000111110, 5'd5, 5'd5, 5'd0, 7'b0001000));       // flush suppresses load-use
    tbl.push_back(mk(9'b000000000, 5'd0, 5'd0, 5'd0, 7'b0001000));
    tbl.push_back(lu);                                                   // back in RUN
    tbl.push_back(mk(9'b101000000, 5'd0, 5'd0, 5'd0, 7'b1110000));       // jump under stall x3
    tbl.push_back(mk(9'b101000000, 5'd0, 5'd0, 5'd0, 7'b1110000));
    tbl.push_back(mk(9'b101000000, 5'd0, 5'd0, 5'd0, 7'b1110000));
    tbl.push_back(mk(9'b001000000, 5'd0, 5'd0, 5'd0, 7'b0000111));
    tbl.push_back(stl);                                                  // stall inside FLUSH holds fcnt
    tbl.push_back(mk(9'b000000000, 5'd0, 5'd0, 5'd0, 7'b0001000));
    tbl.push_back(br);                                                   // redirect in FLUSH reloads fcnt
    tbl.push_back(mk(9'b000000000, 5'd0, 5'd0, 5'd0, 7'b0001000));
    tbl.push_back(mk(9'b000000000, 5'd0, 5'd0, 5'd0, 7'b0001000));
    tbl.push_back(mk(9'b010111110, 5'd5, 5'd5, 5'd0, 7'b0000111));       // redirect beats load-use
    tbl.push_back(mk(9'b000000000, 5'd0, 5'd0, 5'd0, 7'b0001000));
    tbl.push_back(mk(9'b000000000, 5'd0, 5'd0, 5'd0, 7'b0001000));
    tbl.push_back(lu);

    // outputs forced low while reset is held, even with stall and branch asserted
    drive(mk(9'b110111110, 5'd5, 5'd5, 5'd0, 7'b0000000));
    #2;
    check("reset outs", 32'(outs()), 32'd0);
    check("reset stall_cnt", 32'(hz.stall_cnt_o), 32'd0);
    check("reset flush_cnt", 32'(hz.flush_cnt_o), 32'd0);
    @(negedge clk);
    check("reset outs after edge", 32'(outs()), 32'd0);
    rst = 1'b0;
    drive(idle);

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i], $sformatf("vec%0d", i));
    end

    // asynchronous reset in the middle of a flush
    step(br, "pre-reset branch");
    @(posedge clk);
    #1;
    drive(idle);
    #2;
    check("flush before reset", 32'(outs()), 32'b0001000);
    rst = 1'b1;
    #1;
    check("mid-flush reset outs", 32'(outs()), 32'd0);
    check("mid-flush reset stall_cnt", 32'(hz.stall_cnt_o), 32'd0);
    check("mid-flush reset flush_cnt", 32'(hz.flush_cnt_o), 32'd0);
    sc_m = '0;
    fc_m = '0;
    #2;
    rst = 1'b0;

    // 16 stall cycles wrap the 4-bit counter back to zero
    for (int i = 0; i < 16; i++) begin
      step(stl, $sformatf("wrap%0d", i));
    end
    step(idle, "post-wrap idle");
    check("stall_cnt wrapped", 32'(hz.stall_cnt_o), 32'd0);
    step(lu, "RUN after reset");
    step(idle, "final idle");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and sequencing controller for the fetch/decode/ALU/memory pipeline. It detects load-use hazards between the decode stage and the ALU stage and inserts a bubble when one occurs. It turns ALU-stage branch and jump resolution into a PC redirect with a timed front-end flush, and freezes the whole pipeline while the data memory stalls. It also keeps stall and flush performance counters.

## Interface
- REGISTER_WIDTH, params_pkg::REGISTER_WIDTH, width of register specifiers
- FLUSH_CYCLES, 1, extra cycles the fetch output is killed after a redirect, for the in-flight instruction-memory response; legal range 0..15
- CNT_WIDTH, 32, width of the performance counters
- Clock and reset: one clock; reset is asynchronous and active-high.
- clk_i  in  1  clock
- rst_i  in  1  asynchronous, active-high reset
- dec_valid_i  in  1  decode stage holds a valid instruction
- dec_rs_a_i, dec_rs_b_i  in  REGISTER_WIDTH  decode source registers
- dec_uses_a_i, dec_uses_b_i  in  1  the decode instruction actually reads rs_a / rs_b
- alu_valid_i  in  1  ALU stage holds a valid instruction
- alu_is_load_i  in  1  the ALU-stage instruction is LW
- alu_reg_wr_en_i  in  1  the ALU-stage instruction writes a register
- alu_wr_reg_i  in  REGISTER_WIDTH  ALU-stage destination register
- alu_branch_taken_i, alu_is_jump_i  in  1  ALU-stage control-flow resolution (already qualified by valid)
- mem_stall_i  in  1  data memory busy
- fetch_stall_o, decode_stall_o  out  1  hold the PC and the fetch→decode register
- alu_stall_o  out  1  drives the ALU stage stall input (hold the ALU→MEM flops)
- fetch_kill_o  out  1  clear the valid bit entering decode from fetch
- decode_kill_o  out  1  clear the valid bit held in the fetch→decode register
- alu_kill_o  out  1  clear the valid bit entering the ALU stage (bubble)
- pc_redirect_o  out  1  the PC loads the branch/jump target this cycle
- stall_cnt_o, flush_cnt_o  out  CNT_WIDTH  performance counters

## Operation
- States: RUN, FLUSH. There is a flush counter fcnt, 4 bits wide.
- Priority each cycle is mem_stall_i > redirect > load-use.
- **Memory stall (mem_stall_i=1).** All three stall outputs are 1. All kill and redirect outputs are 0. State and fcnt hold. stall_cnt increments.
- **Redirect.** Condition: mem_stall_i=0 and (alu_branch_taken_i | alu_is_jump_i).
  - Outputs: pc_redirect_o=1, decode_kill_o=1, alu_kill_o=1. Stall outputs are 0.
  - If FLUSH_CYCLES>0: next state FLUSH, fcnt=FLUSH_CYCLES. Otherwise the state stays RUN.
  - flush_cnt increments.
  - A redirect in FLUSH state reloads fcnt.
- **Load-use.** Condition: RUN, no mem stall, no redirect, alu_valid_i & alu_is_load_i & alu_reg_wr_en_i & dec_valid_i, and ((dec_uses_a_i & rs_a==alu_wr_reg_i) | (dec_uses_b_i & rs_b==alu_wr_reg_i)).
  - Outputs: fetch_stall_o=1, decode_stall_o=1, alu_kill_o=1. alu_stall_o=0.
  - Exactly one bubble is inserted, because the load leaves the ALU stage next cycle.
  - stall_cnt increments.
  - Register 0 is not special.
- **FLUSH state, no mem stall, no redirect.** fetch_kill_o=1 and fcnt decrements. When fcnt reaches 1, the next state is RUN. Load-use detection is suppressed.
- **Counters.** Both counters wrap modulo 2^CNT_WIDTH.

## Timing
- All stall, kill and redirect outputs are combinational from the current inputs and state, with zero-cycle latency.
- Only the state, fcnt and the counters are registered, on posedge clk_i.
- **Reset.** While rst_i=1:
  - State is RUN, fcnt=0, stall_cnt_o=0, flush_cnt_o=0.
  - All stall, kill and redirect outputs are forced to 0.
  - Reset asserted mid-FLUSH aborts the flush immediately.
- **Redirect while mem_stall_i=1.** No redirect is issued. The ALU stage holds its instruction, so the redirect is issued on the first cycle mem_stall_i is 0.
- **Redirect length.** A redirect followed by FLUSH lasts 1+FLUSH_CYCLES cycles, not counting mem-stall cycles.
- **Simultaneous load-use and redirect.** The redirect wins. The decode instruction is killed, so no stall occurs.

## Structure
- ctrl_state_t (RUN, FLUSH) goes in params_pkg. REGISTER_WIDTH already comes from params_pkg.
- Sub-module: hazard_detect, a combinational load-use comparator. The FSM, fcnt and the counters stay in hazard_ctrl.

## Test plan
- **Load-use.** alu: LW to r5, valid; dec: rs_a=5, uses_a=1 → fetch_stall_o=decode_stall_o=alu_kill_o=1 for exactly 1 cycle; stall_cnt_o=1.
- **Non-hazard.** Same, but uses_a=0, or alu_is_load_i=0 → no stall, no kill.
- **Branch.** alu_branch_taken_i=1, FLUSH_CYCLES=2 → cycle 0: pc_redirect_o=decode_kill_o=alu_kill_o=1; cycles 1–2: fetch_kill_o=1; cycle 3: back in RUN. flush_cnt_o=1.
- **Jump under mem stall.** alu_is_jump_i=1 with mem_stall_i=1 for 3 cycles → three cycles of all-stall with no redirect, then redirect on cycle 3. stall_cnt_o=3.
- **Reset mid-FLUSH.** Assert rst_i asynchronously in FLUSH → outputs 0 immediately; after release the state is RUN and both counters are 0.
- **Counter wrap.** CNT_WIDTH=4, 16 mem-stall cycles → stall_cnt_o wraps to 0.
